ram_io_responder: RTL

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/mem_io_pkg.sv | 26 ++
 rtl/ram_io_responder_if.sv | 30 +++
 rtl/io_byte_fifo.sv | 51 +++++
 rtl/ram_io_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Decode constants, status bit positions and access classification shared by
// the RAM/IO responder and its bench.
package mem_io_pkg;

    localparam logic [1:0] IO_SEL_BITS          = 2'b11;
    localparam logic [2:0] IO_DATA_OFS          = 3'd0;
    localparam logic [2:0] IO_CTRL_OFS          = 3'd4;
    localparam int         STAT_TX_FULL_BIT     = 0;
    localparam int         STAT_RX_NONEMPTY_BIT = 1;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_IO_DATA,
        ACC_IO_CTRL,
        ACC_IO_OTHER
    } acc_kind_e;

    // Only the select bits and the low offset bits take part in the decode.
    function automatic acc_kind_e decode_access(input logic [1:0] sel, input logic [2:0] ofs);
        if (sel != IO_SEL_BITS) return ACC_RAM;
        if (ofs == IO_DATA_OFS) return ACC_IO_DATA;
        if (ofs == IO_CTRL_OFS) return ACC_IO_CTRL;
        return ACC_IO_OTHER;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Memory-controller port plus TX/RX byte streams of the RAM/IO responder.
interface ram_io_responder_if;

    logic [31:0] mem_addr_in;
    logic        mem_rw_in;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        io_buffer_full;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic        halt_out;
    logic        tx_overflow_out;

    modport slave (
        input  mem_addr_in, mem_rw_in, mem_data_in, tx_ready_in, rx_data_in, rx_valid_in,
        output mem_data_out, io_buffer_full, tx_data_out, tx_valid_out, rx_ready_out,
               halt_out, tx_overflow_out
    );

    modport master (
        output mem_addr_in, mem_rw_in, mem_data_in, tx_ready_in, rx_data_in, rx_valid_in,
        input  mem_data_out, io_buffer_full, tx_data_out, tx_valid_out, rx_ready_out,
               halt_out, tx_overflow_out
    );

endinterface

// File: rtl/io_byte_fifo.sv
// Byte FIFO with first-word-fall-through head; push while full is taken only
// when a pop happens in the same cycle.
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped TX/RX byte FIFOs behind one controller port.
// Define IO_RX_EN to build the RX FIFO; otherwise RX reads return zero.
module ram_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8
) (
    input logic               clk,
    input logic               rst,
    ram_io_responder_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]                r_ram [2**RAM_ADDR_WIDTH];
    logic [7:0]                r_data_out;
    logic                      r_halt;
    logic                      r_tx_overflow;
    logic                      r_buf_full;

    acc_kind_e                 w_kind;
    logic                      w_wr;
    logic                      w_rd;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                      w_tx_push;
    logic                      w_tx_pop;
    logic                      w_tx_push_ok;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic [7:0]                w_tx_head;
    logic [CW-1:0]             w_tx_count;
    logic [CW-1:0]             w_tx_count_next;
    logic [7:0]                w_rx_head;
    logic                      w_rx_nonempty;
    logic [7:0]                w_status;
    logic [7:0]                w_io_rdata;
    logic                      w_unused;
    logic                      w_unused_rx;

    assign w_kind    = decode_access(bus.mem_addr_in[17:16], bus.mem_addr_in[2:0]);
    assign w_wr      = bus.mem_rw_in;
    assign w_rd      = !bus.mem_rw_in;
    assign w_ram_idx = bus.mem_addr_in[RAM_ADDR_WIDTH-1:0];
    assign w_unused  = &{1'b0, bus.mem_addr_in};

    assign w_tx_push       = w_wr && (w_kind == ACC_IO_DATA);
    assign w_tx_pop        = !w_tx_empty && bus.tx_ready_in;
    assign w_tx_push_ok    = w_tx_push && (!w_tx_full || w_tx_pop);
    assign w_tx_count_next = w_tx_count + CW'(w_tx_push_ok) - CW'(w_tx_pop);

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (bus.mem_data_in),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    assign bus.tx_valid_out = !w_tx_empty;
    assign bus.tx_data_out  = w_tx_head;

`ifdef IO_RX_EN
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_rx_count;

    // The pop happens on every cycle the data offset is read, even back to back.
    assign w_rx_pop  = w_rd && (w_kind == ACC_IO_DATA) && !w_rx_empty;
    assign w_rx_push = bus.rx_valid_in && !w_rx_full;

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (bus.rx_data_in),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign bus.rx_ready_out = !w_rx_full;
    assign w_rx_nonempty    = !w_rx_empty;
    assign w_unused_rx      = &{1'b0, w_rx_count};
`else
    assign bus.rx_ready_out = 1'b0;
    assign w_rx_head        = 8'h00;
    assign w_rx_nonempty    = 1'b0;
    assign w_unused_rx      = &{1'b0, bus.rx_data_in, bus.rx_valid_in};
`endif

    always_comb begin
        w_status = '0;
        w_status[STAT_TX_FULL_BIT]     = w_tx_full;
        w_status[STAT_RX_NONEMPTY_BIT] = w_rx_nonempty;
        case (w_kind)
            ACC_IO_DATA: w_io_rdata = w_rx_nonempty ? w_rx_head : 8'h00;
            ACC_IO_CTRL: w_io_rdata = w_status;
            default:     w_io_rdata = 8'h00;
        endcase
    end

    // RAM contents survive reset, so the array lives outside the reset block.
    always_ff @(posedge clk) begin
        if (w_wr && (w_kind == ACC_RAM)) r_ram[w_ram_idx] <= bus.mem_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out    <= 8'h00;
            r_halt        <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_buf_full    <= 1'b0;
        end else begin
            if (w_rd) r_data_out <= (w_kind == ACC_RAM) ? r_ram[w_ram_idx] : w_io_rdata;
            r_halt <= w_wr && (w_kind == ACC_IO_CTRL);
            if (w_tx_push && w_tx_full && !w_tx_pop) r_tx_overflow <= 1'b1;
            r_buf_full <= (w_tx_count_next >= CW'(FIFO_DEPTH - 2));
        end
    end

    assign bus.mem_data_out    = r_data_out;
    assign bus.halt_out        = r_halt;
    assign bus.tx_overflow_out = r_tx_overflow;
    assign bus.io_buffer_full  = r_buf_full;

endmodule
